// File: rtl/pe_pkg.sv
// Shared constants, state encoding and a sizing helper for the PE operand feeder.
// Defaults here are the single source for module parameter defaults.
package pe_pkg;

  localparam int SIZE        = 8;
  localparam int L_RAM_SIZE  = 3;
  localparam int VECTOR_SIZE = 2 ** L_RAM_SIZE;
  localparam int TIMEOUT     = 255;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Watchdog counter width, never narrower than one bit.
  function automatic int wd_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pe_feeder_ram.sv
// Operand store: simple dual-port, read-first, registered read port.
// Only the output register is reset; the array keeps its contents.
module pe_feeder_ram
  import pe_pkg::*;
#(
  parameter int DATA_W = SIZE,
  parameter int ADDR_W = L_RAM_SIZE + 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge aclk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Separate read process: a same-cycle write to raddr is seen next access.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pe_feeder.sv
// Loads two operand vectors from an AXI-stream frame, kicks the PE controller,
// waits (with watchdog) for its result and forwards it as one output beat.
module pe_feeder
  import pe_pkg::*;
#(
  parameter int SIZE       = pe_pkg::SIZE,
  parameter int L_RAM_SIZE = pe_pkg::L_RAM_SIZE,
  parameter int TIMEOUT    = pe_pkg::TIMEOUT
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [SIZE-1:0]       s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic                  pe_start,
  input  logic                  pe_done,
  input  logic [L_RAM_SIZE:0]   rdaddr,
  output logic [SIZE-1:0]       rddata,
  input  logic [SIZE-1:0]       pe_result,
  output logic [SIZE-1:0]       m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  err_len,
  output logic                  err_timeout,
  output logic [15:0]           frames_done,
  output state_e                dbg_state_o
);

  localparam int VECTOR_SIZE = 2 ** L_RAM_SIZE;
  localparam int AW          = L_RAM_SIZE + 1;
  localparam int WD_W        = wd_width(TIMEOUT);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(2 * VECTOR_SIZE - 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     wcnt_q, wcnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [SIZE-1:0]   result_q, result_d;
  logic [15:0]       frames_q, frames_d;
  logic              ready_q, ready_d;
  logic              err_len_q, err_len_d;
  logic              err_to_q, err_to_d;
  logic              mem_we;

  // Handshakes: a beat transfers on a rising edge where valid && ready; the
  // source holds data/last stable while valid is high and ready is low.
  // s_tready is registered and equals "state is FILL" outside the first
  // cycle after reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_FILL;
      wcnt_q    <= '0;
      wd_q      <= '0;
      result_q  <= '0;
      frames_q  <= '0;
      ready_q   <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      wd_q      <= wd_d;
      result_q  <= result_d;
      frames_q  <= frames_d;
      ready_q   <= ready_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    wd_d      = wd_q;
    result_d  = result_q;
    frames_d  = frames_q;
    err_len_d = 1'b0;
    err_to_d  = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        if (s_tvalid && ready_q) begin
          mem_we = 1'b1;
          if (wcnt_q == LAST_ADDR) begin
            // A missing tlast on the final beat is flagged but not fatal.
            wcnt_d    = '0;
            err_len_d = !s_tlast;
            state_d   = ST_START;
          end else if (s_tlast) begin
            wcnt_d    = '0;
            err_len_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ST_START: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pe_done) begin
          result_d = pe_result;
          state_d  = ST_OUT;
        end else if (wd_q == WD_LAST) begin
          err_to_d = 1'b1;
          state_d  = ST_FILL;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (m_tready) begin
          frames_d = frames_q + 16'd1;
          state_d  = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase

    ready_d = (state_d == ST_FILL);
  end

  pe_feeder_ram #(
    .DATA_W (SIZE),
    .ADDR_W (AW)
  ) u_ram (
    .aclk    (aclk),
    .aresetn (aresetn),
    .we_i    (mem_we && aresetn),
    .waddr_i (wcnt_q),
    .wdata_i (s_tdata),
    .raddr_i (rdaddr),
    .rdata_o (rddata)
  );

  assign s_tready    = ready_q;
  assign pe_start    = (state_q == ST_START);
  assign m_tvalid    = (state_q == ST_OUT);
  assign m_tdata     = result_q;
  assign m_tlast     = 1'b1;
  assign err_len     = err_len_q;
  assign err_timeout = err_to_q;
  assign frames_done = frames_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: random frames, a memory image model and a result queue.
module tb_pe_feeder;
  import pe_pkg::*;

  localparam int W = 8;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [W-1:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         s_tlast = 1'b0;
  logic         pe_start;
  logic         pe_done = 1'b0;
  logic [3:0]   rdaddr = '0;
  logic [W-1:0] rddata;
  logic [W-1:0] pe_result = '0;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         m_tlast;
  logic         err_len;
  logic         err_timeout;
  logic [15:0]  frames_done;
  state_e       dbg_state;

  always #5 aclk = ~aclk;

  pe_feeder dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .pe_start    (pe_start),
    .pe_done     (pe_done),
    .rdaddr      (rdaddr),
    .rddata      (rddata),
    .pe_result   (pe_result),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .frames_done (frames_done),
    .dbg_state_o (dbg_state)
  );

  int           n_checks = 0;
  int           n_pass = 0;
  logic [W-1:0] mem_model [16];
  bit           mem_known [16];
  logic [W-1:0] frame_data [16];
  logic [15:0]  frames_model = '0;
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_pe_start"}, pe_start, 0);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tdata"}, m_tdata, 0);
    check({tag, "_err_len"}, err_len, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_frames_done"}, frames_done, 0);
    check({tag, "_rddata"}, rddata, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) frame_data[i] = W'($urandom_range(0, 255));
  endtask

  // Drives n beats; probe >= 0 holds rdaddr there to check read-first behaviour.
  task automatic send_beats(input int n, input bit last_at_end, input int probe);
    int guard;
    logic [W-1:0] old;
    if (probe >= 0) rdaddr = 4'(probe);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        tick();
      end
      s_tdata  = frame_data[i];
      s_tlast  = last_at_end && (i == n - 1);
      s_tvalid = 1'b1;
      guard = 0;
      while (!s_tready && guard < 50) begin
        tick();
        guard++;
      end
      if (!s_tready) begin
        check("beat_accept_timeout", 0, 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
      old = mem_model[i];
      tick();
      if (probe == i && mem_known[i]) check("read_first", rddata, old);
      mem_model[i] = frame_data[i];
      mem_known[i] = 1'b1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Entered one cycle after the final beat was taken.
  task automatic run_pe(input bit timeout, input int n_reads, input int hold, input int fixed_res);
    int a;
    bit bad;
    logic [W-1:0] res;
    logic [W-1:0] exp;
    check("pe_start_pulse", pe_start, 1);
    check("start_not_ready", s_tready, 0);
    tick();
    check("pe_start_low_in_wait", pe_start, 0);
    if (timeout) begin
      bad = (err_timeout || m_tvalid || s_tready);
      for (int k = 1; k < TIMEOUT; k++) begin
        tick();
        if (err_timeout || m_tvalid || s_tready) bad = 1'b1;
      end
      check("wait_quiet", bad, 0);
      tick();
      check("err_timeout_pulse", err_timeout, 1);
      check("timeout_ready", s_tready, 1);
      check("timeout_no_tvalid", m_tvalid, 0);
      tick();
      check("err_timeout_clear", err_timeout, 0);
      return;
    end
    for (int r = 0; r < n_reads; r++) begin
      a = (r == 0) ? 5 : (r == 1) ? 15 : int'($urandom_range(0, 15));
      rdaddr = 4'(a);
      tick();
      check("rddata", rddata, mem_model[a]);
    end
    res = (fixed_res >= 0) ? W'(fixed_res) : W'($urandom_range(0, 255));
    exp_q.push_back(res);
    pe_result = res;
    pe_done   = 1'b1;
    tick();
    pe_done   = 1'b0;
    pe_result = ~res;
    exp = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check("out_hold_tvalid", m_tvalid, 1);
      check("out_hold_tdata", m_tdata, exp);
      check("out_hold_tlast", m_tlast, 1);
      tick();
    end
    m_tready = 1'b1;
    check("out_hs_tvalid", m_tvalid, 1);
    check("out_hs_tdata", m_tdata, exp);
    tick();
    m_tready = 1'b0;
    frames_model = frames_model + 16'd1;
    check("out_done_tvalid", m_tvalid, 0);
    check("frames_done", frames_done, frames_model);
    check("back_to_fill_ready", s_tready, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_known[i] = 1'b0;
    aresetn = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    aresetn = 1'b1;

    // Counting frame 0x01..0x10, result 0xA4 held three cycles.
    for (int i = 0; i < 16; i++) frame_data[i] = W'(i + 1);
    send_beats(16, 1'b1, -1);
    check("frame1_err_len", err_len, 0);
    run_pe(1'b0, 2, 3, 'hA4);

    // pe_done while filling has no effect.
    pe_result = 8'h55;
    pe_done   = 1'b1;
    tick();
    pe_done   = 1'b0;
    check("done_ignored_tvalid", m_tvalid, 0);
    check("done_ignored_ready", s_tready, 1);
    check("done_ignored_data", m_tdata, 8'hA4);

    // Early tlast on beat 7 discards the frame.
    fill_random();
    send_beats(7, 1'b1, 3);
    check("short_err_len", err_len, 1);
    check("short_no_start", pe_start, 0);
    check("short_ready", s_tready, 1);
    tick();
    check("short_err_len_clear", err_len, 0);

    fill_random();
    send_beats(16, 1'b1, int'($urandom_range(0, 15)));
    check("after_short_err_len", err_len, 0);
    run_pe(1'b0, 4, int'($urandom_range(0, 3)), -1);

    // Missing tlast on the 16th beat: flagged, load still proceeds.
    fill_random();
    send_beats(16, 1'b0, -1);
    check("no_tlast_err_len", err_len, 1);
    run_pe(1'b0, 3, 1, -1);

    // Watchdog expiry.
    fill_random();
    send_beats(16, 1'b1, -1);
    run_pe(1'b1, 0, 0, -1);

    repeat (4) begin
      fill_random();
      send_beats(16, 1'b1, int'($urandom_range(0, 15)));
      run_pe(1'b0, int'($urandom_range(2, 5)), int'($urandom_range(0, 4)), -1);
    end

    // Reset during beat 9 abandons the frame without an error pulse.
    fill_random();
    send_beats(8, 1'b0, -1);
    s_tdata  = frame_data[8];
    s_tvalid = 1'b1;
    aresetn  = 1'b0;
    tick();
    check_reset_outputs("midreset");
    frames_model = '0;
    aresetn  = 1'b1;
    s_tvalid = 1'b0;
    tick();
    check("midreset_no_err_len", err_len, 0);

    fill_random();
    send_beats(16, 1'b1, -1);
    check("post_reset_err_len", err_len, 0);
    run_pe(1'b0, 4, 2, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
